// File: rtl/mem_arbiter.sv
// Two-requester (instruction/data) arbiter in front of a single-port backing memory.
// Optional macro ARB_RR_EN selects round-robin arbitration; default is fixed D-priority.
module mem_arbiter #(
  parameter int BURST_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [31:0]           i_addr,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [31:0]           d_addr,
  input  logic [31:0]           d_wdata,
  output logic                  i_stall,
  output logic                  d_stall,
  output logic                  i_rvalid,
  output logic                  d_rvalid,
  output logic                  i_done,
  output logic                  d_done,
  output logic [31:0]           rdata,
  output logic [BURST_LOG2-1:0] beat,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;
  localparam int   OFS   = BURST_LOG2 + 2;

  state_t                state_reg, state_next;
  logic                  owner_reg;
  logic                  we_reg;
  logic [31:0]           addr_reg;
  logic [31:0]           wdata_reg;
  logic [BURST_LOG2-1:0] cnt_reg;
  logic                  grant_d;
  logic                  last_beat;
  logic                  beat_fire;
  logic                  any_req;

  assign any_req   = i_req | d_req;
  assign beat_fire = (state_reg == ISSUE) && mem_ack;
  // Writes are always single-beat, so the counter is 0 on their only beat.
  assign last_beat = we_reg || (cnt_reg == {BURST_LOG2{1'b1}});

`ifdef ARB_RR_EN
  logic last_owner_reg;

  assign grant_d = d_req && (!i_req || (last_owner_reg == OWN_I));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_reg <= OWN_I;
    end else if ((state_reg == IDLE) && any_req) begin
      last_owner_reg <= grant_d;
    end
  end
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    i_done     = 1'b0;
    d_done     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_req) state_next = ISSUE;
      end
      ISSUE: begin
        mem_req = 1'b1;
        mem_we  = we_reg;
        if (we_reg) begin
          mem_addr  = {addr_reg[31:2], 2'b00};
          mem_wdata = wdata_reg;
        end else begin
          mem_addr = {addr_reg[31:OFS], cnt_reg, 2'b00};
        end
        if (mem_ack && last_beat) state_next = DONE;
      end
      DONE: begin
        i_done     = (owner_reg == OWN_I);
        d_done     = (owner_reg == OWN_D);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign i_stall = i_req && !((owner_reg == OWN_I) && (state_reg == DONE));
  assign d_stall = d_req && !((owner_reg == OWN_D) && (state_reg == DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_reg <= OWN_D;
      we_reg    <= 1'b0;
      addr_reg  <= 32'h0;
      wdata_reg <= 32'h0;
      cnt_reg   <= '0;
      rdata     <= 32'h0;
      beat      <= '0;
      i_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      if ((state_reg == IDLE) && any_req) begin
        owner_reg <= grant_d;
        we_reg    <= grant_d && d_we;
        addr_reg  <= grant_d ? d_addr : i_addr;
        wdata_reg <= d_wdata;
        cnt_reg   <= '0;
      end
      if (beat_fire) begin
        rdata    <= mem_rdata;
        beat     <= cnt_reg;
        i_rvalid <= !we_reg && (owner_reg == OWN_I);
        d_rvalid <= !we_reg && (owner_reg == OWN_D);
        cnt_reg  <= last_beat ? '0 : cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: memory model returns addr ^ MAGIC,
// expected beats are queued at acceptance and popped on rvalid.
module tb_mem_arbiter;

  localparam logic [31:0] MAGIC = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_stall, d_stall, i_rvalid, d_rvalid, i_done, d_done;
  logic [31:0] rdata;
  logic [1:0]  beat;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  typedef struct {
    logic        side;
    logic [1:0]  beat;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] addr_q[$];
  logic        ack_pat[$];
  logic        exp_we;
  logic [31:0] exp_wdata;
  logic        idle_ack;
  int          rv_cnt;
  int          first_req_cyc;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem_addr ^ MAGIC;

  mem_arbiter #(.BURST_LOG2(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_stall(i_stall), .d_stall(d_stall),
    .i_rvalid(i_rvalid), .d_rvalid(d_rvalid),
    .i_done(i_done), .d_done(d_done),
    .rdata(rdata), .beat(beat),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // Runs one transaction for the given side until its done pulse or the cycle budget expires.
  task automatic service(input logic side, input logic drop, input int budget);
    int          cyc = 0;
    int          bcnt = 0;
    bit          fin = 0;
    bit          held = 0;
    logic [31:0] held_addr = 32'h0;
    logic [31:0] ea;
    exp_t        e;
    rv_cnt = 0;
    first_req_cyc = -1;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      if (i_rvalid || d_rvalid) begin
        rv_cnt++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL rvalid_unexpected: i_rvalid=%b d_rvalid=%b, required none", i_rvalid, d_rvalid);
        end else begin
          e = sb.pop_front();
          if ({d_rvalid, i_rvalid} !== (e.side ? 2'b10 : 2'b01) || rdata !== e.data || beat !== e.beat) begin
            bad++;
            $display("FAIL rvalid_beat: got d/i=%b%b rdata=%h beat=%0d, required side=%0d rdata=%h beat=%0d",
                     d_rvalid, i_rvalid, rdata, beat, e.side, e.data, e.beat);
          end
        end
      end
      if (i_done || d_done) begin
        total++;
        if ({d_done, i_done} !== (side ? 2'b10 : 2'b01) || sb.size() != 0 || addr_q.size() != 0) begin
          bad++;
          $display("FAIL done_pulse: d/i_done=%b%b pending_rv=%0d pending_addr=%0d, required side=%0d with none pending",
                   d_done, i_done, sb.size(), addr_q.size(), side);
        end
        total++;
        if ((side ? d_stall : i_stall) !== 1'b0) begin
          bad++;
          $display("FAIL stall_at_done: got %b, required 0", side ? d_stall : i_stall);
        end
        fin = 1;
        if (drop) begin
          if (side) d_req = 1'b0;
          else i_req = 1'b0;
        end
      end
      if (mem_req) begin
        if (first_req_cyc < 0) first_req_cyc = cyc;
        if (held) begin
          total++;
          if (mem_addr !== held_addr || i_rvalid || d_rvalid) begin
            bad++;
            $display("FAIL hold_on_ack_low: mem_addr=%h rvalid=%b%b, required %h and no rvalid",
                     mem_addr, d_rvalid, i_rvalid, held_addr);
          end
        end
        mem_ack = (ack_pat.size() != 0) ? ack_pat.pop_front() : 1'b1;
        if (mem_ack) begin
          held = 0;
          total++;
          if (addr_q.size() == 0) begin
            bad++;
            $display("FAIL extra_beat: mem_addr=%h accepted, required no further beat", mem_addr);
          end else begin
            ea = addr_q.pop_front();
            if (mem_addr !== ea || mem_we !== exp_we || (exp_we && mem_wdata !== exp_wdata)) begin
              bad++;
              $display("FAIL mem_beat: addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                       mem_addr, mem_we, mem_wdata, ea, exp_we, exp_wdata);
            end
            if (!exp_we) sb.push_back('{side, 2'(bcnt), ea ^ MAGIC});
            bcnt++;
          end
        end else begin
          held = 1;
          held_addr = mem_addr;
        end
      end else begin
        mem_ack = idle_ack;
      end
      if (!fin && cyc > budget) begin
        total++;
        bad++;
        $display("FAIL timeout: no done after %0d cycles, required done", cyc);
        fin = 1;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_req = 0; d_req = 0; d_we = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0;
    mem_ack = 0; idle_ack = 0;
    sb.delete(); addr_q.delete(); ack_pat.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++;
    if (mem_req !== 0 || mem_we !== 0 || mem_addr !== 0 || mem_wdata !== 0) begin
      bad++;
      $display("FAIL reset_mem: req=%b we=%b addr=%h wdata=%h, required all 0", mem_req, mem_we, mem_addr, mem_wdata);
    end
    total++;
    if (rdata !== 0 || beat !== 0 || i_rvalid !== 0 || d_rvalid !== 0 || i_done !== 0 || d_done !== 0) begin
      bad++;
      $display("FAIL reset_rsp: rdata=%h beat=%0d rv=%b%b done=%b%b, required all 0",
               rdata, beat, d_rvalid, i_rvalid, d_done, i_done);
    end
    total++;
    if (i_stall !== 0 || d_stall !== 0) begin
      bad++;
      $display("FAIL reset_stall: i=%b d=%b, required 0", i_stall, d_stall);
    end
  endtask

  task automatic test_ifetch_burst();
    idle_ack = 1'b1;
    i_addr = 32'h0000_0014;
    i_req = 1'b1;
    exp_we = 0;
    addr_q = '{32'h10, 32'h14, 32'h18, 32'h1C};
    service(1'b0, 1'b1, 30);
    total++;
    if (rv_cnt != 4) begin
      bad++;
      $display("FAIL ifetch_rv_count: got %0d, required 4", rv_cnt);
    end
    total++;
    if (first_req_cyc != 1) begin
      bad++;
      $display("FAIL ifetch_latency: mem_req after %0d edges, required 1", first_req_cyc);
    end
    repeat (3) begin
      @(negedge clk);
      total++;
      if (mem_req !== 0 || i_rvalid !== 0 || i_stall !== 0 || i_done !== 0) begin
        bad++;
        $display("FAIL idle_ack_ignored: req=%b rv=%b stall=%b done=%b, required 0", mem_req, i_rvalid, i_stall, i_done);
      end
    end
    idle_ack = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic test_data_write();
    d_we = 1'b1;
    d_addr = 32'h0000_0043;
    d_wdata = 32'hDEAD_BEEF;
    d_req = 1'b1;
    exp_we = 1'b1;
    exp_wdata = 32'hDEAD_BEEF;
    addr_q = '{32'h40};
    ack_pat = '{1'b0};
    @(posedge clk);
    #1;
    d_addr = 32'h0000_1000;
    d_wdata = 32'h0;
    service(1'b1, 1'b1, 20);
    total++;
    if (rv_cnt != 0) begin
      bad++;
      $display("FAIL write_no_rvalid: got %0d rvalids, required 0", rv_cnt);
    end
    d_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ack_stall();
    i_addr = 32'h0000_0238;
    i_req = 1'b1;
    exp_we = 0;
    addr_q = '{32'h230, 32'h234, 32'h238, 32'h23C};
    ack_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    service(1'b0, 1'b1, 30);
    total++;
    if (rv_cnt != 4) begin
      bad++;
      $display("FAIL ackstall_rv_count: got %0d, required 4", rv_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_arbitration();
    logic exp_side;
    do_reset();
    i_addr = 32'h0000_0200;
    d_addr = 32'h0000_0100;
    d_we = 1'b0;
    exp_we = 0;
    i_req = 1'b1;
    d_req = 1'b1;
    for (int t = 0; t < 4; t++) begin
`ifdef ARB_RR_EN
      exp_side = (t % 2 == 0);
`else
      exp_side = 1'b1;
`endif
      if (exp_side) addr_q = '{32'h100, 32'h104, 32'h108, 32'h10C};
      else addr_q = '{32'h200, 32'h204, 32'h208, 32'h20C};
      service(exp_side, 1'b0, 30);
      if (t > 0) begin
        total++;
        if (first_req_cyc != 2) begin
          bad++;
          $display("FAIL back_to_back_gap: mem_req after %0d cycles, required 2", first_req_cyc);
        end
      end
      total++;
      if ((exp_side ? i_stall : d_stall) !== 1'b1) begin
        bad++;
        $display("FAIL nonowner_stall: got %b, required 1", exp_side ? i_stall : d_stall);
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_midburst();
    do_reset();
    i_addr = 32'h0000_0024;
    i_req = 1'b1;
    mem_ack = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (mem_req !== 0 || i_done !== 0 || i_rvalid !== 0 || rdata !== 0 || beat !== 0) begin
      bad++;
      $display("FAIL reset_midburst: req=%b done=%b rv=%b rdata=%h beat=%0d, required all 0",
               mem_req, i_done, i_rvalid, rdata, beat);
    end
    mem_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    ack_pat.delete();
    exp_we = 0;
    addr_q = '{32'h20, 32'h24, 32'h28, 32'h2C};
    service(1'b0, 1'b1, 30);
    total++;
    if (rv_cnt != 4) begin
      bad++;
      $display("FAIL restart_rv_count: got %0d, required 4", rv_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_ifetch_burst();
    test_data_write();
    test_ack_stall();
    test_arbitration();
    test_reset_midburst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
